// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the board reset sequencer.
// Optional watchdog is enabled with RST_SEQ_WDT_EN.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        HOLD,
        STAGE,
        RUN
    } state_t;

    function automatic int cnt_w(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and debounce filter for an active-low key.
// Emits a one-cycle pulse on each debounced press.
module key_debounce
    import rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic key_db,
    output logic key_press
);

    localparam int DW = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] D_MAX = DW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          key_s;
    logic [DW-1:0] dcnt;
    logic          flip;

    assign flip = (key_s != key_db) && (dcnt == D_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            key_s     <= 1'b0;
            key_db    <= 1'b0;
            dcnt      <= '0;
            key_press <= 1'b0;
        end else begin
            sync1     <= key_n;
            key_s     <= sync1;
            key_press <= flip && key_db;
            if (key_s == key_db) begin
                dcnt <= '0;
            end else if (flip) begin
                key_db <= key_s;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rst_sequencer.sv
// Staged reset release for core, SDRAM and peripherals.
// Watchdog restart is compiled in with RST_SEQ_WDT_EN.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STAGE_CYCLES    = 64,
    parameter int WDT_CYCLES      = 1048576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              key_n,
    input  logic              sw_req,
    input  logic              kick,
    output logic [NUM_CH-1:0] rst_out,
    output logic              ready,
    output logic              key_press,
    output logic              wdt_fired
);

    localparam int SW = cnt_w(STAGE_CYCLES);
    localparam int IW = cnt_w(NUM_CH);
    localparam logic [SW-1:0] S_MAX = SW'(STAGE_CYCLES - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

    state_t            state, state_d;
    logic [SW-1:0]     scnt, scnt_d;
    logic [IW-1:0]     idx, idx_d;
    logic [NUM_CH-1:0] rst_q, rst_d;
    logic              ready_q, ready_d;
    logic              key_db;
    logic              wdt_to;
    logic              abort;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .key_db   (key_db),
        .key_press(key_press)
    );

`ifdef RST_SEQ_WDT_EN
    localparam int WW = cnt_w(WDT_CYCLES);
    localparam logic [WW-1:0] W_MAX = WW'(WDT_CYCLES - 1);

    logic [WW-1:0] wcnt;
    logic          fired_q;

    // A kick on the timeout cycle still rescues the system.
    assign wdt_to = (state == RUN) && !kick && (wcnt == W_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            wcnt    <= '0;
            fired_q <= 1'b0;
        end else begin
            if (state != RUN || kick || wdt_to) begin
                wcnt <= '0;
            end else begin
                wcnt <= wcnt + 1'b1;
            end
            if (wdt_to) begin
                fired_q <= 1'b1;
            end
        end
    end

    assign wdt_fired = fired_q;
`else
    logic unused_kick;

    assign unused_kick = kick;
    assign wdt_to      = 1'b0;
    assign wdt_fired   = 1'b0;
`endif

    assign abort = key_press || sw_req || wdt_to;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HOLD;
            scnt    <= '0;
            idx     <= '0;
            rst_q   <= '1;
            ready_q <= 1'b0;
        end else begin
            state   <= state_d;
            scnt    <= scnt_d;
            idx     <= idx_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state;
        scnt_d  = scnt;
        idx_d   = idx;
        rst_d   = rst_q;
        ready_d = ready_q;
        unique case (state)
            HOLD: begin
                rst_d   = '1;
                ready_d = 1'b0;
                idx_d   = '0;
                if (!key_db) begin
                    scnt_d = '0;
                end else if (scnt == S_MAX) begin
                    rst_d  = ~ONE;
                    scnt_d = '0;
                    if (NUM_CH == 1) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        state_d = STAGE;
                        idx_d   = IW'(1);
                    end
                end else begin
                    scnt_d = scnt + 1'b1;
                end
            end
            STAGE: begin
                if (abort) begin
                    state_d = HOLD;
                    scnt_d  = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end else if (scnt == S_MAX) begin
                    rst_d  = rst_q & ~(ONE << idx);
                    scnt_d = '0;
                    if (idx == I_LAST) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end else begin
                    scnt_d = scnt + 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = HOLD;
                    scnt_d  = '0;
                    idx_d   = '0;
                    rst_d   = '1;
                    ready_d = 1'b0;
                end else begin
                    rst_d   = '0;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                scnt_d  = '0;
                idx_d   = '0;
                rst_d   = '1;
                ready_d = 1'b0;
            end
        endcase
    end

    assign rst_out = rst_q;
    assign ready   = ready_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer (NUM_CH=3, DEB=4, STAGE=8, WDT=32).
// Watchdog expectations follow RST_SEQ_WDT_EN.
module tb_rst_sequencer;

    logic       clk;
    logic       reset;
    logic       key_n;
    logic       sw_req;
    logic       kick;
    logic [2:0] rst_out;
    logic       ready;
    logic       key_press;
    logic       wdt_fired;

    int checks;
    int errors;

    rst_sequencer #(
        .NUM_CH         (3),
        .DEBOUNCE_CYCLES(4),
        .STAGE_CYCLES   (8),
        .WDT_CYCLES     (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_n    (key_n),
        .sw_req   (sw_req),
        .kick     (kick),
        .rst_out  (rst_out),
        .ready    (ready),
        .key_press(key_press),
        .wdt_fired(wdt_fired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_rst(input string name, input logic [2:0] exp);
        checks++;
        if (rst_out !== exp) begin
            errors++;
            $display("FAIL %s rst_out=%b expected=%b", name, rst_out, exp);
        end
    endtask

    task automatic chk_rdy(input string name, input logic exp);
        checks++;
        if (ready !== exp) begin
            errors++;
            $display("FAIL %s ready=%b expected=%b", name, ready, exp);
        end
    endtask

    // Full release from HOLD once key_n has just gone (or stays) high
    // with key_db low: 6 cycles debounce + 8 in HOLD, then 8 per stage.
    task automatic run_release(input string name);
        tick(13);
        chk_rst({name, "_hold"}, 3'b111);
        tick(1);
        chk_rst({name, "_ch0"}, 3'b110);
        tick(7);
        chk_rst({name, "_ch0_hold"}, 3'b110);
        tick(1);
        chk_rst({name, "_ch1"}, 3'b100);
        chk_rdy({name, "_rdy_mid"}, 1'b0);
        tick(7);
        chk_rst({name, "_ch1_hold"}, 3'b100);
        tick(1);
        chk_rst({name, "_ch2"}, 3'b000);
        chk_rdy({name, "_rdy"}, 1'b1);
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        key_n  = 1'b0;
        sw_req = 1'b0;
        kick   = 1'b0;
        tick(3);
        chk_rst("reset_rst", 3'b111);
        chk_rdy("reset_rdy", 1'b0);
        checks++;
        if (key_press !== 1'b0 || wdt_fired !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags key_press=%b wdt_fired=%b expected=0 0",
                     key_press, wdt_fired);
        end
    endtask

    task automatic test_power_up;
        reset = 1'b0;
        key_n = 1'b1;
        run_release("pwr");
    endtask

    task automatic test_bounce;
        int bad;
        bad   = 0;
        reset = 1'b1;
        key_n = 1'b0;
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            key_n = (i % 2 == 0) ? 1'b1 : 1'b0;
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (key_press !== 1'b0 || rst_out !== 3'b111) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_quiet bad_cycles=%0d expected=0", bad);
        end
        key_n = 1'b1;
        run_release("bounce");
    endtask

    task automatic test_key_abort;
        key_n = 1'b0;
        tick(5);
        checks++;
        if (key_press !== 1'b0) begin
            errors++;
            $display("FAIL press_early key_press=%b expected=0", key_press);
        end
        tick(1);
        checks++;
        if (key_press !== 1'b1) begin
            errors++;
            $display("FAIL press_pulse key_press=%b expected=1", key_press);
        end
        chk_rst("press_before_abort", 3'b000);
        tick(1);
        checks++;
        if (key_press !== 1'b0) begin
            errors++;
            $display("FAIL press_width key_press=%b expected=0", key_press);
        end
        chk_rst("press_abort", 3'b111);
        chk_rdy("press_abort_rdy", 1'b0);
        tick(3);
        key_n = 1'b1;
        run_release("repress");
    endtask

    task automatic test_sw_req;
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        chk_rst("sw_run_abort", 3'b111);
        chk_rdy("sw_run_rdy", 1'b0);
        tick(7);
        chk_rst("sw_hold", 3'b111);
        tick(1);
        chk_rst("sw_ch0", 3'b110);
        tick(7);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        chk_rst("sw_abort_wins", 3'b111);
        chk_rdy("sw_abort_rdy", 1'b0);
        tick(2);
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        tick(4);
        chk_rst("sw_hold_ignored", 3'b111);
        tick(1);
        chk_rst("sw_hold_timing", 3'b110);
        tick(8);
        chk_rst("sw_ch1", 3'b100);
        tick(8);
        chk_rst("sw_ch2", 3'b000);
        chk_rdy("sw_rdy", 1'b1);
    endtask

    task automatic test_watchdog;
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick(19);
            if (rst_out !== 3'b000 || wdt_fired !== 1'b0) bad++;
            kick = 1'b1;
            tick(1);
            kick = 1'b0;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL wdt_kicked bad_cycles=%0d expected=0", bad);
        end
        tick(31);
        chk_rst("wdt_pre", 3'b000);
        tick(1);
`ifdef RST_SEQ_WDT_EN
        chk_rst("wdt_abort", 3'b111);
        checks++;
        if (wdt_fired !== 1'b1) begin
            errors++;
            $display("FAIL wdt_fired_set wdt_fired=%b expected=1", wdt_fired);
        end
        tick(23);
        chk_rst("wdt_rerelease_pre", 3'b100);
        tick(1);
        chk_rst("wdt_rerelease", 3'b000);
        checks++;
        if (wdt_fired !== 1'b1) begin
            errors++;
            $display("FAIL wdt_fired_sticky wdt_fired=%b expected=1", wdt_fired);
        end
`else
        chk_rst("wdt_off_norestart", 3'b000);
        checks++;
        if (wdt_fired !== 1'b0) begin
            errors++;
            $display("FAIL wdt_off_flag wdt_fired=%b expected=0", wdt_fired);
        end
        tick(24);
        chk_rst("wdt_off_later", 3'b000);
`endif
    endtask

    task automatic test_reset_mid;
        sw_req = 1'b1;
        tick(1);
        sw_req = 1'b0;
        tick(8);
        chk_rst("mid_stage1", 3'b110);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_rst("mid_reset", 3'b111);
        chk_rdy("mid_reset_rdy", 1'b0);
        checks++;
        if (wdt_fired !== 1'b0) begin
            errors++;
            $display("FAIL mid_wdt_clear wdt_fired=%b expected=0", wdt_fired);
        end
        tick(13);
        chk_rst("mid_restart_hold", 3'b111);
        tick(1);
        chk_rst("mid_restart_ch0", 3'b110);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_power_up();
        test_bounce();
        test_key_abort();
        test_sw_req();
        test_watchdog();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
Parametrised board-level reset sequencer for the DE1 vscale system, sitting between the pushbutton (KEY[0]) and the reset inputs of the core, SDRAM controller and peripherals. It synchronises and debounces the active-low pushbutton and holds every reset domain asserted. It then releases NUM_CH reset channels one at a time in index order, STAGE_CYCLES apart, and reasserts all of them on a new button press or a software request.

Parameters:
NUM_CH, 4, number of reset channels released in order 0..NUM_CH-1 (1..16)
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to change the debounced key (>=1)
STAGE_CYCLES, 64, cycles between successive channel releases (>=1)
WDT_CYCLES, 1048576, watchdog timeout in cycles (used only with RST_SEQ_WDT_EN)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high block reset
key_n  input  1  raw pushbutton, active-low (pressed = 0), asynchronous to clk
sw_req  input  1  single-cycle software reset request, synchronous to clk
kick  input  1  watchdog kick, synchronous to clk
rst_out  output  NUM_CH  per-channel reset, active-high
ready  output  1  high when all channels are released
key_press  output  1  one-cycle pulse on a debounced press (1->0)
wdt_fired  output  1  sticky flag: the watchdog forced a restart

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on port reset. No asynchronous logic except the synchroniser input.
- Reset values: rst_out = all ones; ready = 0; key_press = 0; wdt_fired = 0; FSM = HOLD; synchroniser flops and key_db = 0 (treated as pressed); all counters = 0.
- Synchroniser: two flops on key_n give key_s.
- Debounce:
  - dcnt counts consecutive cycles with key_s != key_db, and clears when they are equal.
  - When dcnt reaches DEBOUNCE_CYCLES-1 and key_s still differs, key_db takes key_s on the next edge and dcnt clears.
  - key_press = 1 for exactly the cycle after key_db goes 1->0.
- FSM states: HOLD, STAGE, RUN. Stage index idx is 0..NUM_CH-1 and stage counter scnt is 0..STAGE_CYCLES-1.
- HOLD:
  - rst_out = all ones, ready = 0.
  - scnt increments while key_db = 1 and clears while key_db = 0.
  - At scnt == STAGE_CYCLES-1, rst_out[0] clears, idx <= 1, scnt <= 0, and the FSM goes to STAGE. If NUM_CH == 1 it goes directly to RUN.
- STAGE:
  - scnt increments every cycle.
  - At scnt == STAGE_CYCLES-1, rst_out[idx] clears and scnt <= 0.
  - If idx == NUM_CH-1 the FSM goes to RUN, otherwise idx increments.
  - Once cleared, a channel never reasserts except by an abort.
- RUN: ready = 1 (registered, set on the edge that releases the last channel), rst_out = 0.
- Abort:
  - In STAGE or RUN, a debounced press (key_db falling) or sw_req = 1 causes, on the next edge: rst_out = all ones, ready = 0, scnt = idx = 0, FSM = HOLD.
  - Abort has priority over a same-cycle release.
  - sw_req in HOLD is ignored; scnt is not affected.
- Width: scnt and dcnt use $clog2 of their limit (minimum 1 bit); idx uses $clog2(NUM_CH) (minimum 1 bit). No wrap occurs because the compares saturate.
- Reset mid-sequence returns immediately to the reset values above. A key held low keeps the block in HOLD indefinitely.

Optional Feature:
RST_SEQ_WDT_EN
- Defined:
  - In RUN a watchdog counter wcnt increments each cycle and clears on kick = 1.
  - At wcnt == WDT_CYCLES-1 without a kick, the block aborts as above and sets wdt_fired.
  - wdt_fired clears only on reset.
  - wcnt clears whenever the FSM is not in RUN.
  - A kick in the same cycle as the timeout wins (no abort).
- Undefined: kick is ignored, wdt_fired is tied to 0, and no watchdog counter is instantiated.

Decomposition:
- Package rst_seq_pkg: enum state_t {HOLD, STAGE, RUN} and a function cnt_w(int n) returning max(1, $clog2(n)).
- One sub-module, key_debounce: the two-flop synchroniser, the debounce counter and key_press generation, parametrised by DEBOUNCE_CYCLES. It shares clk and reset with the parent.

Test Plan:
All scenarios use NUM_CH=3, DEBOUNCE_CYCLES=4, STAGE_CYCLES=8, WDT_CYCLES=32.
1. Reset for 3 cycles with key_n=0, then key_n=1 held -> key_db rises 6 cycles after key_n goes high (2 synchroniser + 4 debounce). rst_out then goes 111 -> 110 -> 100 -> 000 at intervals of exactly 8 cycles; ready=1 with the last release.
2. Bounce: key_n toggles every 2 cycles for 20 cycles, then stays 1 -> key_db changes only after 4 stable samples, no key_press pulse appears, and the sequence starts only after the stable period.
3. In RUN, key_n=0 for 10 cycles -> one key_press pulse, and on the following edge rst_out=111 and ready=0. After release the full 3-stage sequence repeats.
4. sw_req pulse on the same cycle rst_out[1] would clear -> rst_out stays 111 (abort wins) and the FSM is in HOLD. A sw_req pulse while in HOLD -> no effect on the timing of scnt.
5. RST_SEQ_WDT_EN defined:
   - Kick every 20 cycles in RUN -> no restart.
   - Stop kicking -> 32 cycles later rst_out=111 and wdt_fired=1; wdt_fired stays 1 after the re-release and clears only on reset.
   - Without the macro, the same stimulus -> wdt_fired=0 and no restart.
6. reset asserted during STAGE (idx=1) -> next edge: rst_out=111, ready=0, wdt_fired=0. The sequence restarts from HOLD.
